// File: rtl/fetch_unit.sv
// fetch_unit: PC -> MAR -> program memory -> IR fetch engine with redirect.
// Define FETCH_PREFETCH_EN for the 2-entry prefetch FIFO variant.
module fetch_unit #(
    parameter int AW      = 5,
    parameter int IW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               pc_load,
    input  logic [AW-1:0]      pc_loadaddr,
    output logic               pm_rd_en,
    output logic [AW-1:0]      pm_addr,
    input  logic [IW-1:0]      pm_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AW+IW-1:0]   fetch_out,
    output logic [AW-1:0]      pc
);

    logic [AW-1:0] pc_q;

    assign pc = pc_q;

`ifdef FETCH_PREFETCH_EN

    logic [MEM_LAT-1:0] inf_q;
    logic [AW-1:0]      tag_q [MEM_LAT];
    logic [AW+IW-1:0]   fifo_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         fifo_cnt_q;
    logic               run_q;
    logic [2:0]         n_inf;
    logic               issue;
    logic               push;
    logic               pop;

    always_comb begin
        n_inf = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            n_inf = n_inf + 3'(inf_q[i]);
        end
    end

    // Slots are reserved at issue time, so a FIFO entry always exists on return
    assign issue = run_q && fetch_en &&
                   (({1'b0, n_inf} + {2'b0, fifo_cnt_q}) < 4'd2);
    assign push  = inf_q[MEM_LAT-1] && !pc_load;
    assign pop   = (fifo_cnt_q != 2'd0) && out_ready && !pc_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            run_q      <= 1'b0;
            inf_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            run_q    <= 1'b1;
            tag_q[0] <= pc_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (pc_load) begin
                pc_q       <= pc_loadaddr;
                inf_q      <= '0;
                rd_ptr_q   <= 1'b0;
                wr_ptr_q   <= 1'b0;
                fifo_cnt_q <= '0;
            end else begin
                if (issue) begin
                    pc_q <= pc_q + 1'b1;
                end
                inf_q[0] <= issue;
                for (int i = 1; i < MEM_LAT; i++) begin
                    inf_q[i] <= inf_q[i-1];
                end
                if (push) begin
                    fifo_q[wr_ptr_q] <= {tag_q[MEM_LAT-1], pm_rdata};
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
            end
        end
    end

    assign pm_rd_en  = issue;
    assign pm_addr   = pc_q;
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign fetch_out = fifo_q[rd_ptr_q];

`else

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        HOLD
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [AW-1:0]      pc_d;
    logic [AW-1:0]      mar_q;
    logic [2:0]         cnt_q;
    logic [AW+IW-1:0]   ir_q;
    logic               vld_q;
    logic               cap;

    assign cap = (state_q == WAIT) && (cnt_q == 3'd0) && !pc_load;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: if (fetch_en) state_d = ADDR;
            ADDR: begin
                state_d = WAIT;
                pc_d    = pc_q + 1'b1;
            end
            WAIT: if (cnt_q == 3'd0) state_d = HOLD;
            HOLD: if (out_ready) state_d = fetch_en ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything, including a same-cycle accept
        if (pc_load) begin
            state_d = fetch_en ? ADDR : IDLE;
            pc_d    = pc_loadaddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            mar_q   <= '0;
            cnt_q   <= '0;
            ir_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_d == ADDR) begin
                mar_q <= pc_d;
            end
            if (state_q == ADDR) begin
                cnt_q <= LAT_M1;
            end else if (cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (cap) begin
                ir_q <= {mar_q, pm_rdata};
            end
            if (pc_load) begin
                vld_q <= 1'b0;
            end else if (cap) begin
                vld_q <= 1'b1;
            end else if ((state_q == HOLD) && out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign pm_rd_en  = (state_q == ADDR);
    assign pm_addr   = mar_q;
    assign out_valid = vld_q;
    assign fetch_out = ir_q;

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a transaction-level model,
// on MEM_LAT=1 and MEM_LAT=3 instances driven in parallel.
module tb_fetch_unit;

    localparam int AW = 5;
    localparam int IW = 32;
    localparam int NL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            fetch_en;
    logic            pc_load;
    logic            out_ready;
    logic [AW-1:0]   pc_loadaddr;

    logic            rd_en [NL];
    logic [AW-1:0]   addr  [NL];
    logic [IW-1:0]   rdata [NL];
    logic            vld   [NL];
    logic [AW+IW-1:0] fout [NL];
    logic [AW-1:0]   pcv   [NL];

    fetch_unit #(.AW(AW), .IW(IW), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .pc_load(pc_load), .pc_loadaddr(pc_loadaddr),
        .pm_rd_en(rd_en[0]), .pm_addr(addr[0]), .pm_rdata(rdata[0]),
        .out_valid(vld[0]), .out_ready(out_ready),
        .fetch_out(fout[0]), .pc(pcv[0])
    );

    fetch_unit #(.AW(AW), .IW(IW), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .pc_load(pc_load), .pc_loadaddr(pc_loadaddr),
        .pm_rd_en(rd_en[1]), .pm_addr(addr[1]), .pm_rdata(rdata[1]),
        .out_valid(vld[1]), .out_ready(out_ready),
        .fetch_out(fout[1]), .pc(pcv[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic st_rn, st_fe, st_rdy, st_ld;
    logic [AW-1:0] st_la;
    logic p_fe, p_ld;

    logic             smp_rd   [NL];
    logic             smp_vld  [NL];
    logic [AW+IW-1:0] smp_out  [NL];
    logic [AW-1:0]    smp_pc   [NL];
    logic [AW-1:0]    smp_addr [NL];

    logic          sched_v [NL][8];
    logic [AW-1:0] sched_a [NL][8];

    logic [AW-1:0]    m_pc   [NL];
    logic [AW-1:0]    m_rd   [NL];
    int               m_last [NL];
    int               m_stall[NL];
    int               m_dlv  [NL];
    logic             m_pvld [NL];
    logic             m_hold [NL];
    logic             m_acc  [NL];
    logic [AW+IW-1:0] m_pout [NL];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_pc[i]    = '0;
        m_rd[i]    = '0;
        m_last[i]  = -100;
        m_stall[i] = 0;
        m_pvld[i]  = 1'b0;
        m_hold[i]  = 1'b0;
        m_acc[i]   = 1'b0;
        m_pout[i]  = '0;
    endtask

    task automatic check_dut(input int i);
        if (!rst_n) begin
            chk("rst_vld",  64'(smp_vld[i]),  0);
            chk("rst_pc",   64'(smp_pc[i]),   0);
            chk("rst_rd",   64'(smp_rd[i]),   0);
            chk("rst_addr", 64'(smp_addr[i]), 0);
            chk("rst_out",  64'(smp_out[i]),  0);
            return;
        end
        chk("pc", 64'(smp_pc[i]), 64'(m_rd[i]));
        if (smp_rd[i]) begin
            chk("rd_addr", 64'(smp_addr[i]), 64'(m_rd[i]));
            chk("rd_gate", 64'(p_fe), 1);
            chk("rd_busy", 64'(smp_vld[i]), 0);
        end
        if (smp_vld[i])
            chk("beat", 64'(smp_out[i]), 64'({m_pc[i], word(m_pc[i])}));
        if (m_hold[i]) begin
            chk("hold_vld", 64'(smp_vld[i]), 1);
            chk("hold_out", 64'(smp_out[i]), 64'(m_pout[i]));
        end
        if (p_ld)
            chk("flush", 64'(smp_vld[i]), 0);
        if (smp_vld[i] && !m_pvld[i])
            chk("lat", 64'(cyc - m_last[i]), 64'(lat(i) + 1));
        if (m_acc[i] && p_fe)
            chk("refetch", 64'(smp_rd[i]), 1);
        if (p_fe && !smp_vld[i] && !smp_rd[i]) m_stall[i]++;
        else m_stall[i] = 0;
        chk("stall", 64'(m_stall[i] <= lat(i)), 1);
    endtask

    task automatic update_model(input int i);
        logic acc;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        if (smp_rd[i]) begin
            m_rd[i]   = m_rd[i] + 1'b1;
            m_last[i] = cyc;
        end
        acc = smp_vld[i] && out_ready && !pc_load;
        if (acc) begin
            m_pc[i] = m_pc[i] + 1'b1;
            m_dlv[i]++;
        end
        if (pc_load) begin
            m_rd[i] = pc_loadaddr;
            m_pc[i] = pc_loadaddr;
        end
        m_hold[i] = smp_vld[i] && !out_ready && !pc_load;
        m_acc[i]  = acc;
        m_pvld[i] = smp_vld[i];
        m_pout[i] = smp_out[i];
    endtask

    task automatic tick();
        logic was_rst;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NL; i++) begin
            smp_rd[i]   = rd_en[i];
            smp_vld[i]  = vld[i];
            smp_out[i]  = fout[i];
            smp_pc[i]   = pcv[i];
            smp_addr[i] = addr[i];
            rdata[i] = sched_v[i][cyc % 8] ?
                       word(sched_a[i][cyc % 8]) : $urandom;
            sched_v[i][cyc % 8] = 1'b0;
            if (smp_rd[i]) begin
                sched_v[i][(cyc + lat(i)) % 8] = 1'b1;
                sched_a[i][(cyc + lat(i)) % 8] = smp_addr[i];
            end
            check_dut(i);
        end
        was_rst     = rst_n;
        rst_n       = st_rn;
        fetch_en    = st_fe;
        out_ready   = st_rdy;
        pc_load     = st_ld;
        pc_loadaddr = st_la;
        if (was_rst && !st_rn) begin
            #1;
            for (int i = 0; i < NL; i++) begin
                chk("async_vld", 64'(vld[i]), 0);
                chk("async_pc",  64'(pcv[i]), 0);
                chk("async_rd",  64'(rd_en[i]), 0);
            end
        end
        for (int i = 0; i < NL; i++) update_model(i);
        p_fe = fetch_en;
        p_ld = pc_load;
    endtask

    task automatic wait_for(input bit want_rd, input int bound);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < bound && !hit; k++) begin
            tick();
            hit = want_rd ? smp_rd[0] : smp_vld[0];
        end
        chk(want_rd ? "wait_rd" : "wait_vld", 64'(hit), 1);
    endtask

    int d0;

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0;
        out_ready = 1'b0; pc_loadaddr = '0;
        p_fe = 1'b0; p_ld = 1'b0;
        for (int i = 0; i < NL; i++) begin
            rdata[i] = '0;
            m_dlv[i] = 0;
            model_reset(i);
            for (int s = 0; s < 8; s++) begin
                sched_v[i][s] = 1'b0;
                sched_a[i][s] = '0;
            end
        end
        st_rn = 1'b0; st_fe = 1'b0; st_rdy = 1'b0;
        st_ld = 1'b0; st_la = '0;
        repeat (3) tick();

        // streaming
        st_rn = 1'b1; st_fe = 1'b1; st_rdy = 1'b1;
        d0 = m_dlv[0];
        repeat (40) tick();
        chk("stream_cnt", 64'(m_dlv[0] - d0 >= 12), 1);

        // backpressure
        st_rdy = 1'b0;
        repeat (10) tick();
        chk("bp_vld", 64'(smp_vld[0]), 1);
        st_rdy = 1'b1;

        // reset in WAIT, then restart from 0
        wait_for(1'b1, 10);
        st_rn = 1'b0;
        repeat (3) tick();
        st_rn = 1'b1;
        repeat (12) tick();

        // redirect during WAIT
        wait_for(1'b1, 10);
        st_ld = 1'b1; st_la = 5'd20;
        tick();
        st_ld = 1'b0; st_rdy = 1'b0;
        wait_for(1'b0, 12);
        chk("redir_pc", 64'(smp_out[0][AW+IW-1:IW]), 20);

        // redirect coincident with a would-be transfer
        st_rdy = 1'b1; st_ld = 1'b1; st_la = 5'd7;
        tick();
        st_ld = 1'b0;
        wait_for(1'b0, 12);
        chk("coinc_pc", 64'(smp_out[0][AW+IW-1:IW]), 7);

        // wrap 31 -> 0
        st_ld = 1'b1; st_la = 5'd31;
        tick();
        st_ld = 1'b0;
        wait_for(1'b0, 12);
        chk("wrap_31", 64'(smp_out[0][AW+IW-1:IW]), 31);
        tick();
        wait_for(1'b0, 12);
        chk("wrap_0", 64'(smp_out[0][AW+IW-1:IW]), 0);

        // fetch_en drop in WAIT
        wait_for(1'b1, 10);
        st_fe = 1'b0;
        d0 = m_dlv[0];
        repeat (12) tick();
        chk("drop_beats", 64'(m_dlv[0] - d0), 1);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            st_fe  = ($urandom % 8) != 0;
            st_rdy = ($urandom % 10) < 7;
            st_ld  = ($urandom % 20) == 0;
            st_la  = AW'($urandom);
            st_rn  = ($urandom % 300) != 0;
            tick();
        end
        st_rn = 1'b1; st_ld = 1'b0;
        repeat (4) tick();
        chk("live0", 64'(m_dlv[0] > 100), 1);
        chk("live1", 64'(m_dlv[1] > 50), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
